offset_move_scheduler: RTL
==========================

Name: offset_move_scheduler

Overview:
- Sequences character-block position updates for the VGA overlay.
- Collects four direction button pulses into per-direction pending flags and arbitrates them round-robin.
- Commits at most one move per frame, on the vertical-blank tick, so moves never tear mid-frame.
- Drives the registered start/end window coordinates that the pixel/ROM read path compares against.

Parameters:
- HDR, 640, horizontal display resolution (pixels)
- VDR, 480, vertical display resolution (lines)
- CHAR_W, 16, scaled character width (HAL*CHM); horizontal step size
- CHAR_H, 32, scaled character height (VAL*CHM); vertical step size

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous, active-low reset
- frameTick  in  1  one-cycle pulse at start of vertical blank
- recenter  in  1  synchronous request to return to center at the next frameTick
- moveReq  in  4  raw button levels {Right, Left, Down, Up}; asynchronous to clk
- posVerStart  out  9  top line of the window
- posVerEnd  out  9  bottom line of the window
- posHorStart  out  10  left pixel of the window
- posHorEnd  out  10  right pixel of the window
- moveAck  out  4  one-hot, one-cycle pulse naming the direction committed
- busy  out  1  high while the FSM is outside IDLE

Behaviour:
- Reset (resetN=0, asynchronous):
  - Outputs go to center: posVerStart=(VDR-CHAR_H)/2=224, posVerEnd=255, posHorStart=(HDR-CHAR_W)/2=312, posHorEnd=327.
  - moveAck=0, busy=0.
  - Pending flags, recenter flag, synchronizers and round-robin pointer are cleared (pointer=Up).
  - Reset asserted mid-operation abandons any in-flight move; nothing commits.
- Input path:
  - Two-flop synchronizer on each moveReq bit, then rising-edge detect.
  - An edge sets pending[d]. The flag saturates: multiple presses within one frame count as one.
  - recenter sets a sticky recenterPend.
- FSM IDLE -> SELECT -> COMPUTE -> COMMIT -> IDLE:
  - IDLE: on frameTick with (recenterPend or any pending), go to SELECT. frameTick is ignored in other states.
  - SELECT: round-robin pick of the first pending bit at or after the pointer, in order Up, Down, Left, Right. The pointer advances to winner+1 mod 4. recenterPend has priority over all directions.
  - COMPUTE: next start computed and registered.
    - Up: vs>=CHAR_H ? vs-CHAR_H : vs+VDR-CHAR_H
    - Down: vs+CHAR_H<=VDR-1 ? vs+CHAR_H : vs+CHAR_H-VDR
    - Left/Right: same rules with hs, CHAR_W, HDR.
  - COMMIT:
    - Start and end update in the same cycle; end=(start+size-1) mod resolution.
    - Clear the served pending bit (or recenterPend; a recenter also clears all direction pending bits).
    - Pulse moveAck for the served direction; moveAck stays 0 for a recenter.
- Latency: frameTick at cycle t gives updated outputs and moveAck visible at t+3.
- Arithmetic is done one bit wider than the output width to avoid overflow before wrap.
- An edge on direction d arriving during SELECT..COMMIT of the same d is retained: the set wins over the clear, and it is served next frame.
- Opposite directions pending together are served in consecutive frames per round-robin order; they are never cancelled.
- Only the non-moved axis holds its value on a commit.

Decomposition:
- Shared package/include holds:
  - HDR/VDR/CHAR_W/CHAR_H constants
  - direction index constants (UP=0, DOWN=1, LEFT=2, RIGHT=3)
  - FSM state encodings
- One natural sub-module: axis_wrap_step. Takes position, size, resolution and direction sign; returns wrapped start and end. It is instantiated once per axis.

Test Plan:
- Reset then idle: outputs 224/255/312/327, busy=0; a frameTick with nothing pending leaves busy=0.
- Left pulse, then frameTick at cycle t:
  - At t+3: posHorStart=296, posHorEnd=311, moveAck=4'b0100.
- Left-edge wrap (posHorStart=8) plus Left:
  - Result posHorStart=632, posHorEnd=7.
  - Right from 624 gives 0/15.
- Down at posVerStart=464:
  - Result posVerStart=16, posVerEnd=47.
  - Up from 0 gives 448/479.
- Up and Left pressed in the same frame:
  - First frameTick serves Up (224->192).
  - Second frameTick serves Left (312->296).
  - Extra presses between ticks produce no third move.
- recenter plus Right pending:
  - Next frameTick returns to 224/255/312/327 with moveAck=0 and Right cleared.
  - resetN pulsed low during COMPUTE: outputs are centered immediately and no moveAck is issued.

Source files
------------

// File: rtl/offset_move_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// offset_move_scheduler_pkg
// Shared constants for the overlay move scheduler:
//   - default display / character geometry
//   - direction indices used for pending flags, moveAck bits and the
//     round-robin pointer
//   - FSM state encoding
//   - round-robin pick helper
// -----------------------------------------------------------------------------
package offset_move_scheduler_pkg;

    localparam int HDR_DEF    = 640;
    localparam int VDR_DEF    = 480;
    localparam int CHAR_W_DEF = 16;
    localparam int CHAR_H_DEF = 32;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SELECT  = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_COMMIT  = 2'd3
    } state_e;

    // First set bit of pend at or after ptr, scanning Up, Down, Left, Right
    // and wrapping. Callers only use the result when pend is non-zero.
    function automatic logic [1:0] rr_pick(input logic [3:0] pend,
                                           input logic [1:0] ptr);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && pend[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/offset_move_scheduler_axis_wrap_step.sv
// -----------------------------------------------------------------------------
// axis_wrap_step
// One-axis position stepper with wrap-around. Moves pos_i by size_i toward
// zero (dec_i=1) or away from it (dec_i=0), wrapping modulo res_i, and
// returns the new window start plus its matching end (start+size-1 mod res).
// Arithmetic is one bit wider than the port width so pos+res never overflows
// before the wrap decision.
// Ports:
//   pos_i   [W-1:0]  current window start
//   size_i  [W-1:0]  step and window size
//   res_i   [W-1:0]  axis resolution
//   dec_i            1 = step toward 0 (Up/Left), 0 = away (Down/Right)
//   start_o [W-1:0]  wrapped new start
//   end_o   [W-1:0]  wrapped new end
// -----------------------------------------------------------------------------
module axis_wrap_step #(
    parameter int W = 10
) (
    input  logic [W-1:0] pos_i,
    input  logic [W-1:0] size_i,
    input  logic [W-1:0] res_i,
    input  logic         dec_i,
    output logic [W-1:0] start_o,
    output logic [W-1:0] end_o
);

    localparam logic [W:0] ONE = (W+1)'(1);

    logic [W:0] pos_w;
    logic [W:0] size_w;
    logic [W:0] res_w;
    logic [W:0] sum_w;
    logic [W:0] start_w;
    logic [W:0] end_w;

    always_comb begin
        pos_w  = {1'b0, pos_i};
        size_w = {1'b0, size_i};
        res_w  = {1'b0, res_i};
        sum_w  = pos_w + size_w;
        if (dec_i) begin
            start_w = (pos_w >= size_w) ? (pos_w - size_w) : (pos_w + res_w - size_w);
        end else begin
            // sum < res is the same test as sum <= res-1
            start_w = (sum_w < res_w) ? sum_w : (sum_w - res_w);
        end
        end_w   = start_w + size_w - ONE;
        start_o = start_w[W-1:0];
        end_o   = W'((end_w >= res_w) ? (end_w - res_w) : end_w);
    end

endmodule

// File: rtl/offset_move_scheduler.sv
// -----------------------------------------------------------------------------
// offset_move_scheduler
// Collects direction button presses into pending flags, arbitrates them
// round-robin and commits at most one window move per frame on frameTick,
// so the overlay never moves mid-frame. A recenter request overrides all
// directions and returns the window to the screen centre.
// Ports:
//   clk          pixel clock
//   resetN       asynchronous active-low reset
//   frameTick    one-cycle pulse at start of vertical blank
//   recenter     request to return to centre at the next frameTick
//   moveReq[3:0] raw button levels {Right, Left, Down, Up}, asynchronous
//   posVerStart/posVerEnd [8:0]  window top/bottom line
//   posHorStart/posHorEnd [9:0]  window left/right pixel
//   moveAck[3:0] one-cycle one-hot pulse naming the committed direction
//   busy         high while the FSM is outside IDLE
// Latency: frameTick sampled at edge t -> new position and moveAck after t+3.
// -----------------------------------------------------------------------------
module offset_move_scheduler
    import offset_move_scheduler_pkg::*;
#(
    parameter int HDR    = HDR_DEF,
    parameter int VDR    = VDR_DEF,
    parameter int CHAR_W = CHAR_W_DEF,
    parameter int CHAR_H = CHAR_H_DEF
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       frameTick,
    input  logic       recenter,
    input  logic [3:0] moveReq,
    output logic [8:0] posVerStart,
    output logic [8:0] posVerEnd,
    output logic [9:0] posHorStart,
    output logic [9:0] posHorEnd,
    output logic [3:0] moveAck,
    output logic       busy
);

    localparam logic [8:0] V_SIZE = 9'(CHAR_H);
    localparam logic [8:0] V_RES  = 9'(VDR);
    localparam logic [8:0] V_CS   = 9'((VDR - CHAR_H) / 2);
    localparam logic [8:0] V_CE   = 9'((VDR - CHAR_H) / 2 + CHAR_H - 1);
    localparam logic [9:0] H_SIZE = 10'(CHAR_W);
    localparam logic [9:0] H_RES  = 10'(HDR);
    localparam logic [9:0] H_CS   = 10'((HDR - CHAR_W) / 2);
    localparam logic [9:0] H_CE   = 10'((HDR - CHAR_W) / 2 + CHAR_W - 1);

    state_e     state_q, state_d;
    logic [3:0] sync1_q, sync2_q, prev_q;
    logic [3:0] rise;
    logic [3:0] pend_q, pend_d;
    logic       rcPend_q, rcPend_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] win_q, win_d;
    logic       winRc_q, winRc_d;
    logic [8:0] nxtVs_q, nxtVs_d, nxtVe_q, nxtVe_d;
    logic [9:0] nxtHs_q, nxtHs_d, nxtHe_q, nxtHe_d;
    logic [8:0] vs_q, vs_d, ve_q, ve_d;
    logic [9:0] hs_q, hs_d, he_q, he_d;
    logic [3:0] ack_q, ack_d;
    logic [8:0] vStepS, vStepE;
    logic [9:0] hStepS, hStepE;

    axis_wrap_step #(.W(9)) u_ver_step (
        .pos_i   (vs_q),
        .size_i  (V_SIZE),
        .res_i   (V_RES),
        .dec_i   (win_q == DIR_UP),
        .start_o (vStepS),
        .end_o   (vStepE)
    );

    axis_wrap_step #(.W(10)) u_hor_step (
        .pos_i   (hs_q),
        .size_i  (H_SIZE),
        .res_i   (H_RES),
        .dec_i   (win_q == DIR_LEFT),
        .start_o (hStepS),
        .end_o   (hStepE)
    );

    // Buttons are asynchronous: two-flop synchronizer, then rising edge.
    assign rise = sync2_q & ~prev_q;

    // FSM: state register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (frameTick && (rcPend_q || (|pend_q))) state_d = ST_SELECT;
            ST_SELECT:  state_d = ST_COMPUTE;
            ST_COMPUTE: state_d = ST_COMMIT;
            ST_COMMIT:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy        = (state_q != ST_IDLE);
        moveAck     = ack_q;
        posVerStart = vs_q;
        posVerEnd   = ve_q;
        posHorStart = hs_q;
        posHorEnd   = he_q;
    end

    // Datapath next-state. New edges are OR-ed in after any clear so a press
    // landing on the commit cycle of the same direction is kept.
    always_comb begin
        pend_d   = pend_q | rise;
        rcPend_d = rcPend_q | recenter;
        ptr_d    = ptr_q;
        win_d    = win_q;
        winRc_d  = winRc_q;
        nxtVs_d  = nxtVs_q;
        nxtVe_d  = nxtVe_q;
        nxtHs_d  = nxtHs_q;
        nxtHe_d  = nxtHe_q;
        vs_d     = vs_q;
        ve_d     = ve_q;
        hs_d     = hs_q;
        he_d     = he_q;
        ack_d    = 4'b0000;
        case (state_q)
            ST_SELECT: begin
                if (rcPend_q) begin
                    winRc_d = 1'b1;
                end else begin
                    winRc_d = 1'b0;
                    win_d   = rr_pick(pend_q, ptr_q);
                    ptr_d   = win_d + 2'd1;
                end
            end
            ST_COMPUTE: begin
                if (winRc_q) begin
                    nxtVs_d = V_CS;
                    nxtVe_d = V_CE;
                    nxtHs_d = H_CS;
                    nxtHe_d = H_CE;
                end else begin
                    // the axis not being moved keeps its current window
                    nxtVs_d = vs_q;
                    nxtVe_d = ve_q;
                    nxtHs_d = hs_q;
                    nxtHe_d = he_q;
                    if (win_q == DIR_UP || win_q == DIR_DOWN) begin
                        nxtVs_d = vStepS;
                        nxtVe_d = vStepE;
                    end else begin
                        nxtHs_d = hStepS;
                        nxtHe_d = hStepE;
                    end
                end
            end
            ST_COMMIT: begin
                vs_d = nxtVs_q;
                ve_d = nxtVe_q;
                hs_d = nxtHs_q;
                he_d = nxtHe_q;
                if (winRc_q) begin
                    // recenter discards every queued direction
                    pend_d   = rise;
                    rcPend_d = recenter;
                end else begin
                    pend_d = (pend_q & ~(4'b0001 << win_q)) | rise;
                    ack_d  = 4'b0001 << win_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync1_q  <= 4'b0000;
            sync2_q  <= 4'b0000;
            prev_q   <= 4'b0000;
            pend_q   <= 4'b0000;
            rcPend_q <= 1'b0;
            ptr_q    <= DIR_UP;
            win_q    <= DIR_UP;
            winRc_q  <= 1'b0;
            nxtVs_q  <= V_CS;
            nxtVe_q  <= V_CE;
            nxtHs_q  <= H_CS;
            nxtHe_q  <= H_CE;
            vs_q     <= V_CS;
            ve_q     <= V_CE;
            hs_q     <= H_CS;
            he_q     <= H_CE;
            ack_q    <= 4'b0000;
        end else begin
            sync1_q  <= moveReq;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            pend_q   <= pend_d;
            rcPend_q <= rcPend_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            winRc_q  <= winRc_d;
            nxtVs_q  <= nxtVs_d;
            nxtVe_q  <= nxtVe_d;
            nxtHs_q  <= nxtHs_d;
            nxtHe_q  <= nxtHe_d;
            vs_q     <= vs_d;
            ve_q     <= ve_d;
            hs_q     <= hs_d;
            he_q     <= he_d;
            ack_q    <= ack_d;
        end
    end

endmodule
